// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers per-unit results in small FIFOs and grants one head per cycle,
// round-robin, onto a registered common data bus feeding the ROB.
module cdb_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_LOG    = 4,
    parameter int DATA_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         flush,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [NUM_SRC-1:0]           src_ready,
    input  logic [NUM_SRC*DATA_W-1:0]    src_value,
    input  logic [NUM_SRC*DATA_W-1:0]    src_topc,
    input  logic [NUM_SRC*ROB_LOG-1:0]   src_robid,
    output logic                         cdb_valid,
    output logic [DATA_W-1:0]            cdb_value,
    output logic [DATA_W-1:0]            cdb_topc,
    output logic [ROB_LOG-1:0]           cdb_robid,
    output logic [$clog2(NUM_SRC)-1:0]   cdb_src
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = 2 * DATA_W + ROB_LOG;

    logic [ENT_W-1:0] mem [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0] head [NUM_SRC];
    logic [PTR_W-1:0] tail [NUM_SRC];
    logic [CNT_W-1:0] count [NUM_SRC];
    logic [SRC_W-1:0] rr_ptr, winner;
    logic             found;
    logic [NUM_SRC-1:0] push, pop;
    logic [ENT_W-1:0] win_ent;

    // Scan from the farthest offset down so the nearest non-empty source after rr_ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (count[(int'(rr_ptr) + k) % NUM_SRC] != '0) begin
                found  = 1'b1;
                winner = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
    end

    assign win_ent = mem[winner][head[winner]];

    always_comb begin
        src_ready = '0;
        push      = '0;
        pop       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH)) && !flush;
            push[i]      = rdy && !flush && src_valid[i] && src_ready[i];
            pop[i]       = rdy && !flush && found && (winner == SRC_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++)
            if (push[i])
                mem[i][tail[i]] <= {src_value[i*DATA_W +: DATA_W], src_topc[i*DATA_W +: DATA_W],
                                    src_robid[i*ROB_LOG +: ROB_LOG]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                count[i] <= '0;
                head[i]  <= '0;
                tail[i]  <= '0;
            end
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_value <= '0;
            cdb_topc  <= '1;
            cdb_robid <= '0;
            cdb_src   <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                count[i] <= '0;
                head[i]  <= '0;
                tail[i]  <= '0;
            end
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
                if (push[i]) tail[i] <= tail[i] + 1'b1;
                if (pop[i])  head[i] <= head[i] + 1'b1;
            end
            cdb_valid <= found;
            if (found) begin
                {cdb_value, cdb_topc, cdb_robid} <= win_ent;
                cdb_src <= winner;
                rr_ptr  <= (winner == SRC_W'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic checked against a
// queue-based model of per-source FIFOs and round-robin broadcast.
module tb_cdb_arbiter;
    localparam int N  = 3;
    localparam int D  = 2;
    localparam int RL = 4;
    localparam int DW = 32;

    logic              clk, rst, rdy, flush;
    logic [N-1:0]      src_valid, src_ready;
    logic [N*DW-1:0]   src_value, src_topc;
    logic [N*RL-1:0]   src_robid;
    logic              cdb_valid;
    logic [DW-1:0]     cdb_value, cdb_topc;
    logic [RL-1:0]     cdb_robid;
    logic [1:0]        cdb_src;

    cdb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D), .ROB_LOG(RL), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_value(src_value), .src_topc(src_topc), .src_robid(src_robid),
        .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_topc(cdb_topc),
        .cdb_robid(cdb_robid), .cdb_src(cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [2*DW+RL-1:0] q [N][$];
    logic          ev;
    logic [DW-1:0] evalue, etopc;
    logic [RL-1:0] erobid;
    int            esrc, rr;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        ev = 1'b0; evalue = '0; etopc = '1; erobid = '0; esrc = 0; rr = 0;
    endtask

    // Called just after a negedge with inputs already driven; advances one clock.
    task automatic step();
        logic [N-1:0] er, acc;
        logic [2*DW+RL-1:0] e;
        int w, s;
        #1;
        for (int i = 0; i < N; i++) er[i] = (q[i].size() != D) && !flush;
        chk("src_ready", 64'(src_ready), 64'(er));
        if (flush) begin
            for (int i = 0; i < N; i++) q[i].delete();
            ev = 1'b0;
            rr = 0;
        end else if (rdy) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                s = (rr + k) % N;
                if (w < 0 && q[s].size() != 0) w = s;
            end
            acc = src_valid & er;
            if (w >= 0) begin
                e = q[w].pop_front();
                {evalue, etopc, erobid} = e;
                esrc = w;
                ev = 1'b1;
                rr = (w + 1) % N;
            end else ev = 1'b0;
            for (int i = 0; i < N; i++)
                if (acc[i]) q[i].push_back({src_value[i*DW +: DW], src_topc[i*DW +: DW], src_robid[i*RL +: RL]});
        end
        @(negedge clk);
        chk("cdb_valid", 64'(cdb_valid), 64'(ev));
        chk("cdb_value", 64'(cdb_value), 64'(evalue));
        chk("cdb_topc", 64'(cdb_topc), 64'(etopc));
        chk("cdb_robid", 64'(cdb_robid), 64'(erobid));
        chk("cdb_src", 64'(cdb_src), 64'(esrc));
    endtask

    task automatic set_src(input int i, input logic [DW-1:0] v, input logic [DW-1:0] t, input logic [RL-1:0] r);
        src_value[i*DW +: DW] = v;
        src_topc[i*DW +: DW]  = t;
        src_robid[i*RL +: RL] = r;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must change without a clock.
    task automatic do_reset();
        flush = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_value", 64'(cdb_value), 64'd0);
        chk("rst_topc", 64'(cdb_topc), 64'hFFFF_FFFF);
        chk("rst_robid", 64'(cdb_robid), 64'd0);
        chk("rst_src", 64'(cdb_src), 64'd0);
        chk("rst_ready", 64'(src_ready), 64'h7);
        #2;
        rst = 1'b0;
    endtask

    task automatic rand_in();
        for (int i = 0; i < N; i++) begin
            src_valid[i] = $urandom_range(0, 3) != 0;
            set_src(i, $urandom, ($urandom_range(0, 3) == 0) ? '1 : $urandom, RL'($urandom));
        end
        rdy   = $urandom_range(0, 7) != 0;
        flush = $urandom_range(0, 24) == 0;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        src_valid = '0; src_value = '0; src_topc = '1; src_robid = '0;
        model_reset();
        #3;
        do_reset();
        @(negedge clk);

        set_src(1, 32'd5, '1, 4'd3);
        src_valid = 3'b010;
        step();
        src_valid = '0;
        step();
        chk("single_value", 64'(cdb_value), 64'd5);
        chk("single_src", 64'(cdb_src), 64'd1);
        step();
        chk("single_idle", 64'(cdb_valid), 64'd0);

        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < N; i++) set_src(i, 32'(10 + i), '1, RL'(i + 1));
        src_valid = 3'b111;
        step();
        src_valid = '0;
        for (int k = 0; k < N; k++) begin
            step();
            chk("contend_robid", 64'(cdb_robid), 64'(k + 1));
            chk("contend_src", 64'(cdb_src), 64'(k));
        end
        step();

        src_valid = 3'b111;
        repeat (12) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        src_valid = '0;
        step();
        chk("flush_idle", 64'(cdb_valid), 64'd0);

        set_src(0, 32'd70, '1, 4'd7);
        src_valid = 3'b001;
        step();
        src_valid = '0;
        step();
        set_src(2, 32'd90, 32'h100, 4'd9);
        src_valid = 3'b100;
        rdy = 1'b0;
        repeat (4) step();
        chk("stall_robid", 64'(cdb_robid), 64'd7);
        chk("stall_valid", 64'(cdb_valid), 64'd1);
        rdy = 1'b1;
        step();
        src_valid = '0;
        step();
        chk("stall_next", 64'(cdb_robid), 64'd9);

        for (int c = 0; c < 3000; c++) begin
            rand_in();
            if (c == 1500) do_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
